// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel button debouncer.
// Holds the per-channel state enum, default tick counts and a counter-width helper.
package debounce_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_QUAL,
      PRESSED,
      HELD,
      REL_QUAL
   } debounce_state_t;

   // Defaults assume the 32.768 kHz system clock.
   localparam int DEF_STABLE_TICKS = 328;
   localparam int DEF_LONG_TICKS   = 32768;
   localparam int DEF_REPEAT_TICKS = 8192;

   // Bits needed to hold 0..ticks.
   function automatic int cnt_width(input int ticks);
      return (ticks < 1) ? 1 : $clog2(ticks + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: 2-flop synchroniser, qualification/hold/repeat
// counters and the press/release state machine.
// Ports:
//   i_clk, i_rst     system clock, synchronous active-high reset
//   i_button_n       raw asynchronous button, 0 = pressed
//   i_repeat_en      auto-repeat enable, sampled every cycle
//   o_debounced_n    debounced level, 0 = pressed
//   o_press          one-cycle pulse on accepted press
//   o_release        one-cycle pulse on accepted release
//   o_long           one-cycle pulse when the press has been held LONG_TICKS
//   o_repeat         one-cycle pulse every REPEAT_TICKS while held and enabled
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_button_n,
   input  logic i_repeat_en,
   output logic o_debounced_n,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int QW = cnt_width(STABLE_TICKS);
   localparam int HW = cnt_width(LONG_TICKS);
   localparam int RW = cnt_width(REPEAT_TICKS);

   localparam logic [QW-1:0] QUAL_LAST = QW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
   localparam logic [QW-1:0] QUAL_ONE  = QW'(1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [RW-1:0] REP_ONE   = RW'(1);

   logic            r_sync1;
   logic            r_sync2;
   debounce_state_t r_state;
   logic [QW-1:0]   r_qual;
   logic [HW-1:0]   r_hold;
   logic [RW-1:0]   r_rep;
   logic            r_from_held;
   logic            r_deb_n;
   logic            r_press;
   logic            r_release;
   logic            r_long;
   logic            r_repeat;

   logic            w_sync_n;
   debounce_state_t w_state;
   logic [QW-1:0]   w_qual;
   logic [HW-1:0]   w_hold;
   logic [RW-1:0]   w_rep;
   logic            w_from_held;
   logic            w_deb_n;
   logic            w_press;
   logic            w_release;
   logic            w_long;
   logic            w_repeat;
   logic            w_adv_pressed;
   logic            w_adv_held;

   assign w_sync_n = r_sync2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_state     <= IDLE;
         r_qual      <= '0;
         r_hold      <= '0;
         r_rep       <= '0;
         r_from_held <= 1'b0;
         r_deb_n     <= 1'b1;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
         r_repeat    <= 1'b0;
      end else begin
         r_sync1     <= i_button_n;
         r_sync2     <= r_sync1;
         r_state     <= w_state;
         r_qual      <= w_qual;
         r_hold      <= w_hold;
         r_rep       <= w_rep;
         r_from_held <= w_from_held;
         r_deb_n     <= w_deb_n;
         r_press     <= w_press;
         r_release   <= w_release;
         r_long      <= w_long;
         r_repeat    <= w_repeat;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_qual        = r_qual;
      w_hold        = r_hold;
      w_rep         = r_rep;
      w_from_held   = r_from_held;
      w_deb_n       = r_deb_n;
      w_press       = 1'b0;
      w_release     = 1'b0;
      w_long        = 1'b0;
      w_repeat      = 1'b0;
      w_adv_pressed = 1'b0;
      w_adv_held    = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (!w_sync_n) begin
               w_state = PRESS_QUAL;
               w_qual  = '0;
            end
         end
         PRESS_QUAL: begin
            if (w_sync_n) begin
               w_state = IDLE;
               w_qual  = '0;
            end else if (r_qual == QUAL_LAST) begin
               w_state = PRESSED;
               w_deb_n = 1'b0;
               w_press = 1'b1;
               w_hold  = '0;
            end else begin
               w_qual = r_qual + QUAL_ONE;
            end
         end
         PRESSED: begin
            if (w_sync_n) begin
               w_state     = REL_QUAL;
               w_qual      = '0;
               w_from_held = 1'b0;
            end else begin
               w_adv_pressed = 1'b1;
            end
         end
         HELD: begin
            if (w_sync_n) begin
               w_state     = REL_QUAL;
               w_qual      = '0;
               w_from_held = 1'b1;
            end else begin
               w_adv_held = 1'b1;
            end
         end
         REL_QUAL: begin
            // The returning cycle also advances the frozen counter, so a
            // glitch delays long/repeat by exactly its own length.
            if (!w_sync_n) begin
               if (r_from_held) begin
                  w_adv_held = 1'b1;
               end else begin
                  w_adv_pressed = 1'b1;
               end
            end else if (r_qual == QUAL_LAST) begin
               w_state   = IDLE;
               w_deb_n   = 1'b1;
               w_release = 1'b1;
            end else begin
               w_qual = r_qual + QUAL_ONE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase

      if (w_adv_pressed) begin
         if (r_hold == HOLD_LAST) begin
            w_state = HELD;
            w_long  = 1'b1;
            w_rep   = '0;
         end else begin
            w_state = PRESSED;
            w_hold  = r_hold + HOLD_ONE;
         end
      end

      if (w_adv_held) begin
         w_state = HELD;
         if (i_repeat_en) begin
            if (r_rep == REP_LAST) begin
               w_repeat = 1'b1;
               w_rep    = '0;
            end else begin
               w_rep = r_rep + REP_ONE;
            end
         end
      end
   end

   assign o_debounced_n = r_deb_n;
   assign o_press       = r_press;
   assign o_release     = r_release;
   assign o_long        = r_long;
   assign o_repeat      = r_repeat;

endmodule

// File: rtl/multi_debouncer.sv
// N independent front-panel button debouncers sharing one clock and reset.
// Ports: clock, reset (sync, active-high); nButton, repeat_en (per channel in);
// debounced_n, press_pulse, release_pulse, long_press, repeat_pulse (per channel out).
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int N_CHANNELS   = 2,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_CHANNELS-1:0] nButton,
   input  logic [N_CHANNELS-1:0] repeat_en,
   output logic [N_CHANNELS-1:0] debounced_n,
   output logic [N_CHANNELS-1:0] press_pulse,
   output logic [N_CHANNELS-1:0] release_pulse,
   output logic [N_CHANNELS-1:0] long_press,
   output logic [N_CHANNELS-1:0] repeat_pulse
);

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_ch (
         .i_clk         (clock),
         .i_rst         (reset),
         .i_button_n    (nButton[g]),
         .i_repeat_en   (repeat_en[g]),
         .o_debounced_n (debounced_n[g]),
         .o_press       (press_pulse[g]),
         .o_release     (release_pulse[g]),
         .o_long        (long_press[g]),
         .o_repeat      (repeat_pulse[g])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (2 channels, 4/20/8 ticks).
// Outputs are sampled 1 time unit after each rising edge.
module tb_multi_debouncer;

   logic       clock;
   logic       reset;
   logic [1:0] nButton;
   logic [1:0] repeat_en;
   logic [1:0] debounced_n;
   logic [1:0] press_pulse;
   logic [1:0] release_pulse;
   logic [1:0] long_press;
   logic [1:0] repeat_pulse;

   int n_checks;
   int n_fail;

   multi_debouncer #(
      .N_CHANNELS   (2),
      .STABLE_TICKS (4),
      .LONG_TICKS   (20),
      .REPEAT_TICKS (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .nButton       (nButton),
      .repeat_en     (repeat_en),
      .debounced_n   (debounced_n),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .repeat_pulse  (repeat_pulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] ep;
      logic [1:0] ed;
      reset     = 1'b1;
      nButton   = 2'b00;
      repeat_en = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({debounced_n, press_pulse, release_pulse, long_press, repeat_pulse}
             !== 10'b11_00_00_00_00) begin
            n_fail++;
            $display("FAIL reset_state cyc%0d: got %b want 1100000000", i,
                     {debounced_n, press_pulse, release_pulse, long_press, repeat_pulse});
         end
      end
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         ep = (k == 7) ? 2'b11 : 2'b00;
         ed = (k >= 7) ? 2'b00 : 2'b11;
         n_checks++;
         if (press_pulse !== ep) begin
            n_fail++;
            $display("FAIL reset_press edge%0d: got %b want %b", k, press_pulse, ep);
         end
         n_checks++;
         if (debounced_n !== ed) begin
            n_fail++;
            $display("FAIL reset_level edge%0d: got %b want %b", k, debounced_n, ed);
         end
      end
      nButton = 2'b11;
      for (int k = 1; k <= 10; k++) begin
         step();
         ep = (k == 7) ? 2'b11 : 2'b00;
         ed = (k >= 7) ? 2'b11 : 2'b00;
         n_checks++;
         if (release_pulse !== ep || press_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release edge%0d: got rel=%b press=%b want rel=%b press=00",
                     k, release_pulse, press_pulse, ep);
         end
         n_checks++;
         if (debounced_n !== ed) begin
            n_fail++;
            $display("FAIL reset_rel_level edge%0d: got %b want %b", k, debounced_n, ed);
         end
      end
   endtask

   task automatic test_press_bounce();
      logic [1:0] ep;
      logic [1:0] ed;
      nButton = 2'b11;
      for (int t = 0; t < 6; t++) begin
         nButton[0] = (t % 2 == 1);
         for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (press_pulse !== 2'b00 || debounced_n !== 2'b11) begin
               n_fail++;
               $display("FAIL bounce_quiet t%0d: got press=%b deb=%b want press=00 deb=11",
                        t, press_pulse, debounced_n);
            end
         end
      end
      nButton[0] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         ep = (k == 7) ? 2'b01 : 2'b00;
         ed = (k >= 7) ? 2'b10 : 2'b11;
         n_checks++;
         if (press_pulse !== ep) begin
            n_fail++;
            $display("FAIL bounce_press edge%0d: got %b want %b", k, press_pulse, ep);
         end
         n_checks++;
         if (debounced_n !== ed) begin
            n_fail++;
            $display("FAIL bounce_level edge%0d: got %b want %b", k, debounced_n, ed);
         end
      end
      nButton = 2'b11;
      for (int k = 1; k <= 10; k++) begin
         step();
         ep = (k == 7) ? 2'b01 : 2'b00;
         n_checks++;
         if (release_pulse !== ep) begin
            n_fail++;
            $display("FAIL bounce_release edge%0d: got %b want %b", k, release_pulse, ep);
         end
      end
   endtask

   task automatic test_long_repeat(input logic en);
      logic [1:0] ep;
      logic [1:0] el;
      logic [1:0] er;
      logic       rep_hit;
      repeat_en = {en, 1'b0};
      nButton   = 2'b01;
      for (int k = 1; k <= 60; k++) begin
         step();
         rep_hit = (k == 35) || (k == 43) || (k == 51) || (k == 59);
         ep = (k == 7)  ? 2'b10 : 2'b00;
         el = (k == 27) ? 2'b10 : 2'b00;
         er = (en && rep_hit) ? 2'b10 : 2'b00;
         n_checks++;
         if (press_pulse !== ep) begin
            n_fail++;
            $display("FAIL long_press_pulse en%0b edge%0d: got %b want %b", en, k, press_pulse, ep);
         end
         n_checks++;
         if (long_press !== el) begin
            n_fail++;
            $display("FAIL long_pulse en%0b edge%0d: got %b want %b", en, k, long_press, el);
         end
         n_checks++;
         if (repeat_pulse !== er) begin
            n_fail++;
            $display("FAIL repeat_pulse en%0b edge%0d: got %b want %b", en, k, repeat_pulse, er);
         end
      end
      nButton = 2'b11;
      for (int k = 1; k <= 10; k++) begin
         step();
         ep = (k == 7) ? 2'b10 : 2'b00;
         n_checks++;
         if (release_pulse !== ep || repeat_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL long_release en%0b edge%0d: got rel=%b rep=%b want rel=%b rep=00",
                     en, k, release_pulse, repeat_pulse, ep);
         end
      end
      repeat_en = 2'b00;
   endtask

   task automatic test_release_glitch();
      logic [1:0] el;
      logic [1:0] ed;
      nButton = 2'b10;
      for (int k = 1; k <= 32; k++) begin
         step();
         el = (k == 29) ? 2'b01 : 2'b00;
         ed = (k >= 7) ? 2'b10 : 2'b11;
         n_checks++;
         if (long_press !== el) begin
            n_fail++;
            $display("FAIL glitch_long edge%0d: got %b want %b", k, long_press, el);
         end
         n_checks++;
         if (release_pulse !== 2'b00 || debounced_n !== ed) begin
            n_fail++;
            $display("FAIL glitch_level edge%0d: got rel=%b deb=%b want rel=00 deb=%b",
                     k, release_pulse, debounced_n, ed);
         end
         if (k == 10) nButton = 2'b11;
         if (k == 12) nButton = 2'b10;
      end
   endtask

   task automatic test_reset_held();
      logic [1:0] ep;
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if ({debounced_n, press_pulse, release_pulse, long_press, repeat_pulse}
          !== 10'b11_00_00_00_00) begin
         n_fail++;
         $display("FAIL held_reset: got %b want 1100000000",
                  {debounced_n, press_pulse, release_pulse, long_press, repeat_pulse});
      end
      for (int k = 1; k <= 10; k++) begin
         step();
         ep = (k == 7) ? 2'b01 : 2'b00;
         n_checks++;
         if (press_pulse !== ep || release_pulse !== 2'b00) begin
            n_fail++;
            $display("FAIL held_repress edge%0d: got press=%b rel=%b want press=%b rel=00",
                     k, press_pulse, release_pulse, ep);
         end
      end
      nButton = 2'b11;
      for (int k = 1; k <= 10; k++) begin
         step();
         ep = (k == 7) ? 2'b01 : 2'b00;
         n_checks++;
         if (release_pulse !== ep) begin
            n_fail++;
            $display("FAIL held_release edge%0d: got %b want %b", k, release_pulse, ep);
         end
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      nButton   = 2'b11;
      repeat_en = 2'b00;
      test_reset();
      test_press_bounce();
      test_long_repeat(1'b1);
      test_long_repeat(1'b0);
      test_release_glitch();
      test_reset_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
